// File: rtl/math_divider_pkg.sv
// Shared constants for the sequential divider: FSM encodings and counter sizing.
package math_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter counts N-1 down to 0, so $clog2(N) bits are enough.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/math_divider_as_block.sv
// One bit of the trial subtraction with the restore mux folded in.
module math_divider_as_block (
  input  logic a,
  input  logic b,
  input  logic bin,
  input  logic q,
  output logic d,
  output logic bout
);

  logic diff;

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
  // q=1 keeps the difference, q=0 restores the minuend bit.
  assign d    = q ? diff : a;

endmodule

// File: rtl/math_divider_seq.sv
// Unsigned restoring divider: one quotient bit per RUN cycle, MSB first.
import math_divider_pkg::*;

module math_divider_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CNT_W = cnt_width(N);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N:0]       rem_q, rem_d;
  logic [N-1:0]     quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [N:0]       trial_a, trial_b, rem_nxt;
  logic             keep;
  logic             unused_rem_msb;

  // After a restore the partial remainder is below the divisor, so its MSB is always 0.
  assign unused_rem_msb = rem_q[N];
  assign trial_a = {rem_q[N-1:0], dvd_q[N-1]};
  assign trial_b = {1'b0, dvs_q};

  for (genvar i = 0; i <= N; i++) begin : g_bit
    logic bin_w, bout_w;
    if (i == 0) begin : g_lsb
      assign bin_w = 1'b0;
    end else begin : g_chain
      assign bin_w = g_bit[i-1].bout_w;
    end
    math_divider_as_block u_as (
      .a   (trial_a[i]),
      .b   (trial_b[i]),
      .bin (bin_w),
      .q   (keep),
      .d   (rem_nxt[i]),
      .bout(bout_w)
    );
  end

  // No borrow out of the top bit means the trial difference is non-negative.
  assign keep = ~g_bit[N].bout_w;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(N - 1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = rem_nxt;
        quo_d = {quo_q[N-2:0], keep};
        dvd_d = dvd_q << 1;
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          quotient_d  = {quo_q[N-2:0], keep};
          remainder_d = rem_nxt[N-1:0];
          dbz_d       = (dvs_q == '0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_math_divider_seq.sv
// Directed and small randomized checks of the sequential divider at N=8.
module tb_math_divider_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int cmp_cnt = 0;
  int err_cnt = 0;

  math_divider_seq #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one division from IDLE and follows it into the cycle after done.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z,
                         output int lat, output logic busy_ok, output logic post_ok);
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0;
    lat = 0; busy_ok = 1'b1; post_ok = 1'b0;
    q = 'x; r = 'x; z = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
    end
    if (lat != 0) begin
      if (busy !== 1'b0) busy_ok = 1'b0;
      q = quotient; r = remainder; z = div_by_zero;
      step();
      post_ok = (done === 1'b0) && (busy === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step();
    step();
    cmp_cnt += 5;
    if (quotient !== 8'd0) begin err_cnt++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    if (remainder !== 8'd0) begin err_cnt++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
    if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] q, r;
    logic z, bok, pok;
    int lat;
    run_div(8'd100, 8'd7, q, r, z, lat, bok, pok);
    cmp_cnt += 6;
    if (q !== 8'd14) begin err_cnt++; $display("FAIL basic_quotient: got %0d want 14", q); end
    if (r !== 8'd2) begin err_cnt++; $display("FAIL basic_remainder: got %0d want 2", r); end
    if (z !== 1'b0) begin err_cnt++; $display("FAIL basic_dbz: got %b want 0", z); end
    if (lat != 9) begin err_cnt++; $display("FAIL basic_latency: got %0d want 9", lat); end
    if (bok !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: busy profile wrong, want high exactly cycles 1..8"); end
    if (pok !== 1'b1) begin err_cnt++; $display("FAIL basic_after_done: done/busy not low after done cycle"); end
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'd255, 8'd0, 8'd3,  8'd255, 8'd128, 8'd254};
    logic [7:0] vb [6] = '{8'd1,   8'd5, 8'd10, 8'd255, 8'd3,   8'd16};
    logic [7:0] vq [6] = '{8'd255, 8'd0, 8'd0,  8'd1,   8'd42,  8'd15};
    logic [7:0] vr [6] = '{8'd0,   8'd0, 8'd3,  8'd0,   8'd2,   8'd14};
    logic [7:0] q, r;
    logic z, bok, pok;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_div(va[i], vb[i], q, r, z, lat, bok, pok);
      cmp_cnt += 4;
      if (q !== vq[i] || r !== vr[i])
        begin err_cnt++; $display("FAIL vec_result %0d/%0d: got %0d r%0d want %0d r%0d", va[i], vb[i], q, r, vq[i], vr[i]); end
      if (z !== 1'b0) begin err_cnt++; $display("FAIL vec_dbz %0d/%0d: got %b want 0", va[i], vb[i], z); end
      if (lat != 9) begin err_cnt++; $display("FAIL vec_latency %0d/%0d: got %0d want 9", va[i], vb[i], lat); end
      if (bok !== 1'b1 || pok !== 1'b1) begin err_cnt++; $display("FAIL vec_handshake %0d/%0d: busy=%b post=%b want 1 1", va[i], vb[i], bok, pok); end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] va [2] = '{8'd200, 8'd0};
    logic [7:0] q, r;
    logic z, bok, pok;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_div(va[i], 8'd0, q, r, z, lat, bok, pok);
      cmp_cnt += 4;
      if (q !== 8'd255) begin err_cnt++; $display("FAIL dz_quotient %0d/0: got %0d want 255", va[i], q); end
      if (r !== va[i]) begin err_cnt++; $display("FAIL dz_remainder %0d/0: got %0d want %0d", va[i], r, va[i]); end
      if (z !== 1'b1) begin err_cnt++; $display("FAIL dz_flag %0d/0: got %b want 1", va[i], z); end
      if (lat != 9) begin err_cnt++; $display("FAIL dz_latency %0d/0: got %0d want 9", va[i], lat); end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int first_k = 0;
    logic [7:0] q = '0, r = '0;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    for (int k = 1; k <= 25; k++) begin
      start = 1'b0;
      if (k == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd3; end
      if (done === 1'b1) begin
        dones++;
        if (first_k == 0) begin first_k = k; q = quotient; r = remainder; end
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      end
      step();
    end
    start = 1'b0;
    cmp_cnt += 5;
    if (dones != 1) begin err_cnt++; $display("FAIL ign_done_count: got %0d want 1", dones); end
    if (first_k != 9) begin err_cnt++; $display("FAIL ign_latency: got %0d want 9", first_k); end
    if (q !== 8'd14 || r !== 8'd2) begin err_cnt++; $display("FAIL ign_result: got %0d r%0d want 14 r2", q, r); end
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL ign_idle: busy got %b want 0", busy); end
    if (quotient !== 8'd14 || remainder !== 8'd2) begin err_cnt++; $display("FAIL ign_hold: got %0d r%0d want 14 r2", quotient, remainder); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] q, r;
    logic z, bok, pok;
    int lat;
    int spurious = 0;
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    cmp_cnt += 2;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0)
      begin err_cnt++; $display("FAIL rstmid_results: got q=%0d r=%0d z=%b want 0 0 0", quotient, remainder, div_by_zero); end
    if (busy !== 1'b0 || done !== 1'b0)
      begin err_cnt++; $display("FAIL rstmid_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
      step();
    end
    cmp_cnt += 1;
    if (spurious != 0) begin err_cnt++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", spurious); end
    run_div(8'd100, 8'd7, q, r, z, lat, bok, pok);
    cmp_cnt += 2;
    if (q !== 8'd14 || r !== 8'd2) begin err_cnt++; $display("FAIL rstmid_after: got %0d r%0d want 14 r2", q, r); end
    if (lat != 9) begin err_cnt++; $display("FAIL rstmid_latency: got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r;
    logic z, bok, pok;
    int lat;
    run_div(8'd128, 8'd3, q, r, z, lat, bok, pok);
    start = 1'b1; dividend = 8'd254; divisor = 8'd16;
    step();
    start = 1'b0;
    cmp_cnt += 1;
    if (busy !== 1'b1 || quotient !== 8'd42 || remainder !== 8'd2)
      begin err_cnt++; $display("FAIL b2b_hold: got busy=%b %0d r%0d want 1 42 r2", busy, quotient, remainder); end
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (done === 1'b1) begin lat = k; break; end
      step();
    end
    cmp_cnt += 2;
    if (lat != 9) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    if (quotient !== 8'd15 || remainder !== 8'd14)
      begin err_cnt++; $display("FAIL b2b_result: got %0d r%0d want 15 r14", quotient, remainder); end
    step();
  endtask

  task automatic test_random();
    logic [7:0] a, b, q, r, eq, er;
    logic z, bok, pok;
    int lat;
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 50 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
      eq = (b == 0) ? 8'd255 : a / b;
      er = (b == 0) ? a : a % b;
      run_div(a, b, q, r, z, lat, bok, pok);
      cmp_cnt += 1;
      if (q !== eq || r !== er || z !== (b == 0) || lat != 9 || bok !== 1'b1 || pok !== 1'b1)
        begin err_cnt++; $display("FAIL rand %0d/%0d: got %0d r%0d z%b lat%0d want %0d r%0d z%b lat9", a, b, q, r, z, lat, eq, er, (b == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/math_divider_seq.md
MATH_DIVIDER_SEQ -- requirements
Module: math_divider_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, setting operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, N bits: unsigned numerator, sampled with start.
REQ-006 The block SHALL have port divisor, input, N bits: unsigned denominator, sampled with start.
REQ-007 The block SHALL have port quotient, output, N bits: unsigned result.
REQ-008 The block SHALL have port remainder, output, N bits: unsigned result.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: set with done when the latched divisor was 0.

Function
REQ-012 The block SHALL implement unsigned restoring division, producing one quotient bit per RUN cycle, MSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, the block SHALL latch dividend and divisor, clear the (N+1)-bit partial remainder, load the bit counter with N-1, and enter RUN.
REQ-015 Each RUN cycle SHALL shift {partial remainder, next dividend bit} left by one, subtract the divisor, keep the difference and shift in quotient bit 1 if non-negative, else restore and shift in 0.
REQ-016 RUN SHALL last exactly N cycles; when the counter reaches 0, the block SHALL enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 With start sampled high on edge t, busy SHALL be 1 in cycles t+1..t+N and done SHALL be 1 in cycle t+N+1 only.
REQ-019 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-020 start SHALL be ignored in RUN and DONE; a new start is accepted no earlier than the cycle after DONE.
REQ-021 For divisor=0, the block SHALL use the same latency and produce quotient = all ones, remainder = dividend, and div_by_zero=1.
REQ-022 For divisor!=0, results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-023 The intermediate subtraction SHALL be N+1 bits wide so that no overflow is possible for any operands.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE and clear quotient, remainder, busy, done, div_by_zero, counter and all internal registers to 0.
REQ-025 Asserting rst mid-RUN SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-026 State encodings and the counter-width constant ($clog2(N)) SHALL reside in a shared package, math_divider_pkg.
REQ-027 The one-bit subtract/restore step SHALL be a sub-module, math_divider_as_block, with inputs a, b, bin, q and outputs d, bout. It is instantiated N+1 times as a ripple row; the restore mux is selected by the final borrow.
REQ-028 The datapath SHALL be purely synchronous apart from the asynchronous reset, with no combinational path from inputs to outputs.

Verification
REQ-029 N=8, dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 9 cycles after the start edge.
REQ-030 N=8: 255/1 -> 255 r0; 0/5 -> 0 r0; 3/10 -> 0 r3; 255/255 -> 1 r0.
REQ-031 N=8, dividend=200, divisor=0 -> quotient=255, remainder=200, div_by_zero=1, same latency.
REQ-032 Apply start plus new operands during RUN and during DONE -> ignored; results reflect only the first operands, and exactly one done pulse is produced.
REQ-033 Assert rst at RUN cycle 4 -> all outputs 0 immediately, no done; then 100/7 -> 14 r2.
REQ-034 Run a randomized regression of 10k operand pairs at N=8 and N=16 against a reference model, checking REQ-022 and REQ-018 on every transaction.
